// File: rtl/rf_wb_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | rf_wb_arbiter_pkg : shared constants/types for the writeback arbiter |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package rf_wb_arbiter_pkg;
  localparam int REQ_ALU    = 0;
  localparam int REQ_LSU    = 1;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_arb.sv
// +--------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin arbiter with registered pointer      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  localparam logic PTR_RESET = 1'(REQ_ALU);

  logic ptr_q;
  logic ptr_d;

  // The pointer only advances on contention; a lone requester leaves it alone.
  always_comb begin
    o_grant = '0;
    ptr_d   = ptr_q;
    if (!rst) begin
      if (i_valid == 2'b11) begin
        o_grant[ptr_q] = 1'b1;
        ptr_d          = ~ptr_q;
      end else begin
        o_grant = i_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_RESET;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// +--------------------------------------------------------------------+
// | rf_wb_arbiter : regfile write-port arbiter, scoreboard and bypass  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_waddr_5,
  input  logic [XLEN-1:0] i_alu_wdata_32,
  output logic            o_alu_ready,
  input  logic            i_lsu_valid,
  input  logic [4:0]      i_lsu_waddr_5,
  input  logic [XLEN-1:0] i_lsu_wdata_32,
  output logic            o_lsu_ready,
  output logic            o_rf_wen,
  output logic [4:0]      o_rf_waddr_5,
  output logic [XLEN-1:0] o_rf_wdata_32,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd_5,
  input  logic [4:0]      i_raddr1_5,
  input  logic [4:0]      i_raddr2_5,
  input  logic [XLEN-1:0] i_rf_rdata1_32,
  input  logic [XLEN-1:0] i_rf_rdata2_32,
  output logic [XLEN-1:0] o_rdata1_32,
  output logic [XLEN-1:0] o_rdata2_32,
  output logic            o_raw_hazard,
  output logic            o_waw_hazard
);
  import rf_wb_arbiter_pkg::*;

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_grant;

  assign req_valid[REQ_ALU] = i_alu_valid;
  assign req_valid[REQ_LSU] = i_lsu_valid;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid (req_valid),
    .o_grant (req_grant)
  );

  assign o_alu_ready = req_grant[REQ_ALU];
  assign o_lsu_ready = req_grant[REQ_LSU];

  logic            wen_q,   wen_d;
  reg_addr_t       waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     pending_q, pending_d;

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (|req_grant) begin
      waddr_d = req_grant[REQ_LSU] ? i_lsu_waddr_5  : i_alu_waddr_5;
      wdata_d = req_grant[REQ_LSU] ? i_lsu_wdata_32 : i_alu_wdata_32;
      wen_d   = (waddr_d != ZERO_REG);
    end
  end

  // Clear first so that an issue to the same register on this edge wins.
  always_comb begin
    pending_d = pending_q;
    if (wen_q) begin
      pending_d[waddr_q] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd_5 != ZERO_REG)) begin
      pending_d[i_issue_rd_5] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign o_rf_wen      = wen_q;
  assign o_rf_waddr_5  = waddr_q;
  assign o_rf_wdata_32 = wdata_q;

  logic byp1, byp2;

  assign byp1 = wen_q && (waddr_q == i_raddr1_5) && (i_raddr1_5 != ZERO_REG);
  assign byp2 = wen_q && (waddr_q == i_raddr2_5) && (i_raddr2_5 != ZERO_REG);

  assign o_rdata1_32 = (i_raddr1_5 == ZERO_REG) ? '0 : (byp1 ? wdata_q : i_rf_rdata1_32);
  assign o_rdata2_32 = (i_raddr2_5 == ZERO_REG) ? '0 : (byp2 ? wdata_q : i_rf_rdata2_32);

  assign o_raw_hazard = (pending_q[i_raddr1_5] && !byp1) ||
                        (pending_q[i_raddr2_5] && !byp2);
  assign o_waw_hazard = i_issue_valid && pending_q[i_issue_rd_5];

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_rf_wb_arbiter : directed self-checking bench for rf_wb_arbiter  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_waddr, lsu_waddr, issue_rd, raddr1, raddr2;
  logic [31:0] alu_wdata, lsu_wdata, rf_rdata1, rf_rdata2;
  logic        alu_ready, lsu_ready, rf_wen, raw_hazard, waw_hazard;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rdata1, rdata2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(2), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_alu_valid    (alu_valid),
    .i_alu_waddr_5  (alu_waddr),
    .i_alu_wdata_32 (alu_wdata),
    .o_alu_ready    (alu_ready),
    .i_lsu_valid    (lsu_valid),
    .i_lsu_waddr_5  (lsu_waddr),
    .i_lsu_wdata_32 (lsu_wdata),
    .o_lsu_ready    (lsu_ready),
    .o_rf_wen       (rf_wen),
    .o_rf_waddr_5   (rf_waddr),
    .o_rf_wdata_32  (rf_wdata),
    .i_issue_valid  (issue_valid),
    .i_issue_rd_5   (issue_rd),
    .i_raddr1_5     (raddr1),
    .i_raddr2_5     (raddr2),
    .i_rf_rdata1_32 (rf_rdata1),
    .i_rf_rdata2_32 (rf_rdata2),
    .o_rdata1_32    (rdata1),
    .o_rdata2_32    (rdata2),
    .o_raw_hazard   (raw_hazard),
    .o_waw_hazard   (waw_hazard)
  );

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'hAAAA_0001;
    lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'hBBBB_0002;
    issue_valid = 1'b0; issue_rd = 5'd0;
    raddr1 = 5'd0; raddr2 = 5'd0; rf_rdata1 = '0; rf_rdata2 = '0;
    tick(); tick();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", rf_wen); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL reset_alu_ready got=%b exp=0", alu_ready); end
    total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL reset_lsu_ready got=%b exp=0", lsu_ready); end
    total++; if (raw_hazard !== 1'b0 || waw_hazard !== 1'b0) begin bad++; $display("FAIL reset_hazards got=%b%b exp=00", raw_hazard, waw_hazard); end
    total++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wport got=%0d/%h exp=0/0", rf_waddr, rf_wdata); end
    rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_not_retained got=%b exp=0", rf_wen); end
    total++; if (waw_hazard !== 1'b1) begin bad++; $display("FAIL reset_waw5 got=%b exp=1", waw_hazard); end
    issue_valid = 1'b0; raddr1 = 5'd5;
    #1;
    total++; if (raw_hazard !== 1'b1) begin bad++; $display("FAIL reset_raw5 got=%b exp=1", raw_hazard); end
    // retire x5 so later tests start with an empty scoreboard
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h5;
    tick();
    alu_valid = 1'b0; raddr1 = 5'd0;
    tick();
    raddr1 = 5'd5;
    #1;
    total++; if (raw_hazard !== 1'b0) begin bad++; $display("FAIL reset_x5_cleared got=%b exp=0", raw_hazard); end
    raddr1 = 5'd0;
  endtask

  task automatic test_contention();
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h11;
    lsu_valid = 1'b1; lsu_waddr = 5'd4; lsu_wdata = 32'h22;
    #1;
    total++; if ({alu_ready, lsu_ready} !== 2'b10) begin bad++; $display("FAIL cont_grant1 got=%b%b exp=10", alu_ready, lsu_ready); end
    tick();
    total++; if ({alu_ready, lsu_ready} !== 2'b01) begin bad++; $display("FAIL cont_grant2 got=%b%b exp=01", alu_ready, lsu_ready); end
    total++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin bad++; $display("FAIL cont_write1 got=%b/%0d/%h exp=1/3/11", rf_wen, rf_waddr, rf_wdata); end
    tick();
    total++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h22}) begin bad++; $display("FAIL cont_write2 got=%b/%0d/%h exp=1/4/22", rf_wen, rf_waddr, rf_wdata); end
    total++; if ({alu_ready, lsu_ready} !== 2'b10) begin bad++; $display("FAIL cont_ptr_back got=%b%b exp=10", alu_ready, lsu_ready); end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    total++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin bad++; $display("FAIL cont_idle_hold got=%b/%0d/%h exp=0/4/22", rf_wen, rf_waddr, rf_wdata); end
  endtask

  task automatic test_lone();
    lsu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lsu_waddr = 5'(10 + i); lsu_wdata = 32'h100 + 32'(i);
      #1;
      total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL lone_ready%0d got=%b exp=1", i, lsu_ready); end
      tick();
      total++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'(10 + i), 32'h100 + 32'(i)}) begin bad++; $display("FAIL lone_write%0d got=%b/%0d/%h", i, rf_wen, rf_waddr, rf_wdata); end
    end
    alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'hA;
    lsu_waddr = 5'd2; lsu_wdata = 32'hB;
    #1;
    total++; if ({alu_ready, lsu_ready} !== 2'b10) begin bad++; $display("FAIL lone_ptr_kept got=%b%b exp=10", alu_ready, lsu_ready); end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'hDEAD_BEEF;
    raddr2 = 5'd7; rf_rdata2 = 32'h1234_5678;
    #1;
    total++; if (raw_hazard !== 1'b1) begin bad++; $display("FAIL byp_raw_before got=%b exp=1", raw_hazard); end
    tick();
    alu_valid = 1'b0;
    #1;
    total++; if (rdata2 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_data got=%h exp=deadbeef", rdata2); end
    total++; if (raw_hazard !== 1'b0) begin bad++; $display("FAIL byp_raw_during got=%b exp=0", raw_hazard); end
    tick();
    total++; if (raw_hazard !== 1'b0) begin bad++; $display("FAIL byp_pending_clear got=%b exp=0", raw_hazard); end
    total++; if (rdata2 !== 32'h1234_5678) begin bad++; $display("FAIL byp_passthru got=%h exp=12345678", rdata2); end
    raddr2 = 5'd0;
  endtask

  task automatic test_x0();
    issue_valid = 1'b1; issue_rd = 5'd0;
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFF_FFFF;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL x0_accept got=%b exp=1", alu_ready); end
    total++; if (waw_hazard !== 1'b0) begin bad++; $display("FAIL x0_waw got=%b exp=0", waw_hazard); end
    tick();
    issue_valid = 1'b0; alu_valid = 1'b0;
    raddr1 = 5'd0; rf_rdata1 = 32'h5555_5555;
    #1;
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b exp=0", rf_wen); end
    total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL x0_rdata got=%h exp=0", rdata1); end
    total++; if (raw_hazard !== 1'b0) begin bad++; $display("FAIL x0_raw got=%b exp=0", raw_hazard); end
    raddr1 = 5'd3; rf_rdata1 = 32'h0000_CAFE;
    #1;
    total++; if (rdata1 !== 32'h0000_CAFE) begin bad++; $display("FAIL x0_rf_path got=%h exp=cafe", rdata1); end
    raddr1 = 5'd0;
    tick();
  endtask

  task automatic test_collision();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h99;
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9) begin bad++; $display("FAIL coll_write got=%b/%0d exp=1/9", rf_wen, rf_waddr); end
    tick();
    issue_valid = 1'b0; raddr1 = 5'd9;
    #1;
    total++; if (raw_hazard !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b exp=1", raw_hazard); end
    raddr1 = 5'd0; issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    total++; if (waw_hazard !== 1'b1) begin bad++; $display("FAIL coll_waw got=%b exp=1", waw_hazard); end
    issue_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_lone();
    test_bypass();
    test_x0();
    test_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
